// File: rtl/ram_arbiter.sv
// Shares a single-port RAM between the instruction-fetch and load/store stages.
// Requests are level-held; each completes with a one-cycle ready pulse.
module ram_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RAM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_stall,
    output logic              ram_re,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W = $clog2(RAM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_wait;
    logic [3:0]        r_starve;
    logic              r_owner_if;
    logic              r_ram_re;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_address;
    logic [DATA_W-1:0] r_ram_data;
    logic [DATA_W-1:0] r_rdata;
    logic              r_if_ready;
    logic              r_mem_ready;

    logic w_mem_req;
    logic w_any_req;
    logic w_starved;
    logic w_if_wins;

    assign w_mem_req = mem_re | mem_we;
    assign w_any_req = if_req | w_mem_req;
    assign w_starved = (STARVE_LIMIT != 0) && (r_starve == 4'(STARVE_LIMIT));
    assign w_if_wins = if_req & (~w_mem_req | w_starved);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_wait        <= '0;
            r_starve      <= '0;
            r_owner_if    <= 1'b0;
            r_ram_re      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_rdata       <= '0;
            r_if_ready    <= 1'b0;
            r_mem_ready   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state    <= ACCESS;
                        r_wait     <= CNT_W'(RAM_LAT);
                        r_owner_if <= w_if_wins;
                        if (w_if_wins) begin
                            r_ram_address <= if_addr;
                            r_ram_re      <= 1'b1;
                            r_starve      <= '0;
                        end else begin
                            r_ram_address <= mem_addr;
                            // A simultaneous read+write request is served as a write.
                            if (mem_we) begin
                                r_ram_we   <= 1'b1;
                                r_ram_data <= mem_wdata;
                            end else begin
                                r_ram_re <= 1'b1;
                            end
                            if (if_req && (r_starve != 4'hF)) begin
                                r_starve <= r_starve + 4'd1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    r_ram_re <= 1'b0;
                    r_ram_we <= 1'b0;
                    if (r_ram_we) begin
                        r_state     <= RESP;
                        r_if_ready  <= r_owner_if;
                        r_mem_ready <= ~r_owner_if;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // The last WAIT cycle is the one where ram_rdata is valid.
                    if (r_wait == CNT_W'(1)) begin
                        r_rdata     <= ram_rdata;
                        r_state     <= RESP;
                        r_if_ready  <= r_owner_if;
                        r_mem_ready <= ~r_owner_if;
                    end else begin
                        r_wait <= r_wait - CNT_W'(1);
                    end
                end
                RESP: begin
                    r_if_ready  <= 1'b0;
                    r_mem_ready <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ram_re      = r_ram_re;
    assign ram_we      = r_ram_we;
    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;
    assign if_rdata    = r_rdata;
    assign mem_rdata   = r_rdata;
    assign if_ready    = r_if_ready;
    assign mem_ready   = r_mem_ready;
    assign if_stall    = if_req & ~r_if_ready;
    assign mem_stall   = w_mem_req & ~r_mem_ready;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: default config, pure MEM priority, and RAM_LAT=3.
module tb_ram_arbiter;

    localparam logic [31:0] KEY = 32'hDEAD_BEAF;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    // Instance A: defaults (RAM_LAT=1, STARVE_LIMIT=4)
    logic        a_if_req, a_if_ready, a_if_stall, a_mem_re, a_mem_we, a_mem_ready, a_mem_stall;
    logic        a_ram_re, a_ram_we;
    logic [31:0] a_if_addr, a_if_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [31:0] a_ram_address, a_ram_data, a_ram_rdata;
    // Instance B: STARVE_LIMIT=0
    logic        b_if_req, b_if_ready, b_if_stall, b_mem_re, b_mem_we, b_mem_ready, b_mem_stall;
    logic        b_ram_re, b_ram_we;
    logic [31:0] b_if_addr, b_if_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [31:0] b_ram_address, b_ram_data, b_ram_rdata;
    // Instance C: RAM_LAT=3
    logic        c_if_req, c_if_ready, c_if_stall, c_mem_re, c_mem_we, c_mem_ready, c_mem_stall;
    logic        c_ram_re, c_ram_we;
    logic [31:0] c_if_addr, c_if_rdata, c_mem_addr, c_mem_wdata, c_mem_rdata;
    logic [31:0] c_ram_address, c_ram_data, c_ram_rdata;

    ram_arbiter u_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata),
        .if_ready(a_if_ready), .if_stall(a_if_stall),
        .mem_re(a_mem_re), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .mem_ready(a_mem_ready), .mem_stall(a_mem_stall),
        .ram_re(a_ram_re), .ram_we(a_ram_we), .ram_address(a_ram_address),
        .ram_data(a_ram_data), .ram_rdata(a_ram_rdata)
    );

    ram_arbiter #(.STARVE_LIMIT(0)) u_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
        .if_ready(b_if_ready), .if_stall(b_if_stall),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready), .mem_stall(b_mem_stall),
        .ram_re(b_ram_re), .ram_we(b_ram_we), .ram_address(b_ram_address),
        .ram_data(b_ram_data), .ram_rdata(b_ram_rdata)
    );

    ram_arbiter #(.RAM_LAT(3)) u_c (
        .clk(clk), .rst(rst),
        .if_req(c_if_req), .if_addr(c_if_addr), .if_rdata(c_if_rdata),
        .if_ready(c_if_ready), .if_stall(c_if_stall),
        .mem_re(c_mem_re), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
        .mem_rdata(c_mem_rdata), .mem_ready(c_mem_ready), .mem_stall(c_mem_stall),
        .ram_re(c_ram_re), .ram_we(c_ram_we), .ram_address(c_ram_address),
        .ram_data(c_ram_data), .ram_rdata(c_ram_rdata)
    );

    // RAM models: read data (addr ^ KEY) is valid only in the exact latency cycle.
    logic [31:0] a_q, b_q, c_q1, c_q2, c_q3;
    always @(posedge clk) begin
        a_q  <= a_ram_re ? (a_ram_address ^ KEY) : 32'hBAD0_BAD0;
        b_q  <= b_ram_re ? (b_ram_address ^ KEY) : 32'hBAD0_BAD0;
        c_q1 <= c_ram_re ? (c_ram_address ^ KEY) : 32'hBAD0_BAD0;
        c_q2 <= c_q1;
        c_q3 <= c_q2;
    end
    assign a_ram_rdata = a_q;
    assign b_ram_rdata = b_q;
    assign c_ram_rdata = c_q3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        {a_if_req, a_mem_re, a_mem_we} = '0;
        {b_if_req, b_mem_re, b_mem_we} = '0;
        {c_if_req, c_mem_re, c_mem_we} = '0;
        {a_if_addr, a_mem_addr, a_mem_wdata} = '0;
        {b_if_addr, b_mem_addr, b_mem_wdata} = '0;
        {c_if_addr, c_mem_addr, c_mem_wdata} = '0;
        step();
        step();

        // Reset state
        check("rst_ram_re", 32'(a_ram_re), 32'd0);
        check("rst_ram_we", 32'(a_ram_we), 32'd0);
        check("rst_ram_address", a_ram_address, 32'd0);
        check("rst_ram_data", a_ram_data, 32'd0);
        check("rst_if_ready", 32'(a_if_ready), 32'd0);
        check("rst_mem_ready", 32'(a_mem_ready), 32'd0);
        check("rst_rdata", a_if_rdata, 32'd0);
        rst = 1'b0;

        // IF read of 0x40, expect 0xDEADBEEF in cycle 3
        a_if_req  = 1'b1;
        a_if_addr = 32'h40;
        #1;
        check("ifrd_c0_stall", 32'(a_if_stall), 32'd1);
        check("ifrd_c0_ram_re", 32'(a_ram_re), 32'd0);
        step();
        check("ifrd_c1_ram_re", 32'(a_ram_re), 32'd1);
        check("ifrd_c1_addr", a_ram_address, 32'h40);
        check("ifrd_c1_stall", 32'(a_if_stall), 32'd1);
        step();
        check("ifrd_c2_ram_re", 32'(a_ram_re), 32'd0);
        check("ifrd_c2_ready", 32'(a_if_ready), 32'd0);
        check("ifrd_c2_stall", 32'(a_if_stall), 32'd1);
        step();
        check("ifrd_c3_ready", 32'(a_if_ready), 32'd1);
        check("ifrd_c3_rdata", a_if_rdata, 32'hDEAD_BEEF);
        check("ifrd_c3_stall", 32'(a_if_stall), 32'd0);
        check("ifrd_c3_mem_ready", 32'(a_mem_ready), 32'd0);
        a_if_req = 1'b0;
        step();
        check("ifrd_c4_ready", 32'(a_if_ready), 32'd0);

        // MEM write 0x100 <- 0x12345678
        a_mem_we    = 1'b1;
        a_mem_addr  = 32'h100;
        a_mem_wdata = 32'h1234_5678;
        #1;
        check("wr_c0_stall", 32'(a_mem_stall), 32'd1);
        step();
        check("wr_c1_ram_we", 32'(a_ram_we), 32'd1);
        check("wr_c1_ram_re", 32'(a_ram_re), 32'd0);
        check("wr_c1_addr", a_ram_address, 32'h100);
        check("wr_c1_data", a_ram_data, 32'h1234_5678);
        step();
        check("wr_c2_ram_we", 32'(a_ram_we), 32'd0);
        check("wr_c2_ready", 32'(a_mem_ready), 32'd1);
        check("wr_c2_stall", 32'(a_mem_stall), 32'd0);
        check("wr_c2_rdata_kept", a_mem_rdata, 32'hDEAD_BEEF);
        a_mem_we = 1'b0;
        step();
        check("wr_c3_ready", 32'(a_mem_ready), 32'd0);

        // Both reading continuously: MEM x4 then IF, repeating
        a_if_req   = 1'b1;
        a_if_addr  = 32'h200;
        a_mem_re   = 1'b1;
        a_mem_addr = 32'h300;
        for (int t = 0; t < 10; t++) begin
            logic exp_if;
            exp_if = ((t % 5) == 4);
            step();
            check($sformatf("arb%0d_addr", t), a_ram_address, exp_if ? 32'h200 : 32'h300);
            step();
            step();
            check($sformatf("arb%0d_if_ready", t), 32'(a_if_ready), 32'(exp_if));
            check($sformatf("arb%0d_mem_ready", t), 32'(a_mem_ready), 32'(!exp_if));
            check($sformatf("arb%0d_rdata", t), a_if_rdata,
                  exp_if ? (32'h200 ^ KEY) : (32'h300 ^ KEY));
            step();
        end
        a_if_req = 1'b0;
        a_mem_re = 1'b0;
        step();

        // Reset during WAIT aborts the read; held request reissues afterwards
        a_mem_re   = 1'b1;
        a_mem_addr = 32'h500;
        step();
        check("rstw_c1_ram_re", 32'(a_ram_re), 32'd1);
        step();
        rst = 1'b1;
        #1;
        check("rstw_addr_cleared", a_ram_address, 32'd0);
        check("rstw_ram_re", 32'(a_ram_re), 32'd0);
        check("rstw_ready", 32'(a_mem_ready), 32'd0);
        step();
        check("rstw_no_pulse", 32'(a_mem_ready), 32'd0);
        rst = 1'b0;
        step();
        check("rstw_reissue_re", 32'(a_ram_re), 32'd1);
        check("rstw_reissue_addr", a_ram_address, 32'h500);
        step();
        check("rstw_wait_ready", 32'(a_mem_ready), 32'd0);
        step();
        check("rstw_ready_after", 32'(a_mem_ready), 32'd1);
        check("rstw_rdata", a_mem_rdata, 32'h500 ^ KEY);
        a_mem_re = 1'b0;
        step();

        // mem_re and mem_we together are a write
        a_mem_re    = 1'b1;
        a_mem_we    = 1'b1;
        a_mem_addr  = 32'h600;
        a_mem_wdata = 32'hA5A5_5A5A;
        step();
        check("rw_c1_ram_we", 32'(a_ram_we), 32'd1);
        check("rw_c1_ram_re", 32'(a_ram_re), 32'd0);
        check("rw_c1_data", a_ram_data, 32'hA5A5_5A5A);
        step();
        check("rw_c2_ready", 32'(a_mem_ready), 32'd1);
        check("rw_c2_ram_re", 32'(a_ram_re), 32'd0);
        check("rw_c2_rdata_kept", a_mem_rdata, 32'h500 ^ KEY);
        a_mem_re = 1'b0;
        a_mem_we = 1'b0;
        step();

        // STARVE_LIMIT=0: IF never wins while MEM requests
        b_if_req   = 1'b1;
        b_if_addr  = 32'h200;
        b_mem_re   = 1'b1;
        b_mem_addr = 32'h300;
        for (int t = 0; t < 6; t++) begin
            step();
            check($sformatf("pure%0d_addr", t), b_ram_address, 32'h300);
            step();
            step();
            check($sformatf("pure%0d_if_ready", t), 32'(b_if_ready), 32'd0);
            check($sformatf("pure%0d_mem_ready", t), 32'(b_mem_ready), 32'd1);
            step();
        end
        b_mem_re = 1'b0;
        step();
        check("pure_if_addr", b_ram_address, 32'h200);
        step();
        step();
        check("pure_if_ready", 32'(b_if_ready), 32'd1);
        check("pure_if_rdata", b_if_rdata, 32'h200 ^ KEY);
        b_if_req = 1'b0;
        step();

        // RAM_LAT=3: ram_re in cycle 1, mem_ready in cycle 5
        c_mem_re   = 1'b1;
        c_mem_addr = 32'h700;
        #1;
        check("lat3_c0_ram_re", 32'(c_ram_re), 32'd0);
        step();
        check("lat3_c1_ram_re", 32'(c_ram_re), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("lat3_c%0d_ram_re", k), 32'(c_ram_re), 32'd0);
            check($sformatf("lat3_c%0d_ready", k), 32'(c_mem_ready), 32'd0);
        end
        step();
        check("lat3_c5_ready", 32'(c_mem_ready), 32'd1);
        check("lat3_c5_rdata", c_mem_rdata, 32'h700 ^ KEY);
        c_mem_re = 1'b0;
        step();
        check("lat3_c6_ready", 32'(c_mem_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequences the single-port data/instruction RAM and shares it between the instruction-fetch port (IF) and the load/store stage (MEM).
- Replaces direct MEM-stage drive of the RAM strobes: each requester presents a level request and receives a one-cycle ready pulse plus a stall.
- Registered RAM-side strobes. Fixed MEM priority with an IF anti-starvation counter. Configurable RAM read latency.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RAM_LAT, 1, cycles from ram_re-high cycle to ram_rdata valid (≥1)
STARVE_LIMIT, 4, consecutive MEM wins over a waiting IF before IF is forced (0 = pure MEM priority; max 15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active high
if_req  in  1  IF read request (level)
if_addr  in  ADDR_W  IF read address
if_rdata  out  DATA_W  read data, valid with if_ready
if_ready  out  1  one-cycle completion pulse
if_stall  out  1  if_req & ~if_ready
mem_re  in  1  MEM read request (level)
mem_we  in  1  MEM write request (level)
mem_addr  in  ADDR_W  MEM address
mem_wdata  in  DATA_W  MEM write data
mem_rdata  out  DATA_W  read data, valid with mem_ready
mem_ready  out  1  one-cycle completion pulse
mem_stall  out  1  (mem_re|mem_we) & ~mem_ready
ram_re  out  1  RAM read strobe
ram_we  out  1  RAM write strobe
ram_address  out  ADDR_W  RAM address
ram_data  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (async, immediate): state IDLE. All of the following go to 0: ram_re, ram_we, ram_address, ram_data, if_ready, mem_ready, rdata register (drives both if_rdata and mem_rdata), starve counter. An in-flight access is aborted with no ready pulse. Requesters still holding req are re-served after release.
- Handshake: requester holds req, address and wdata stable until its ready pulse. It deasserts req in the cycle after ready unless it wants a new access. If req drops mid-access, the access completes and the ready pulse is still emitted but is ignored.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE, cycle N:
  - No request: stay in IDLE.
  - Any request: arbitrate and, at the edge, register ram_address, ram_data (write only), ram_re/ram_we and owner. Next state ACCESS. Load wait counter with RAM_LAT.
- ACCESS, cycle N+1: exactly one strobe is high for this single cycle. At the edge, clear strobes; a write goes to RESP, a read goes to WAIT.
- WAIT: counter decrements each cycle. In the cycle where ram_rdata is valid (N+1+RAM_LAT), capture ram_rdata into the rdata register at the edge and go to RESP.
- RESP: owner's ready = 1 for one cycle, then IDLE.
- Latency, request seen to ready:
  - Write: 2 cycles.
  - Read: 2+RAM_LAT cycles (3 at default).
  - Minimum issue spacing: write 3 cycles, read 3+RAM_LAT cycles.
- Arbitration in IDLE:
  - Only one requester: it wins.
  - Both requesting: MEM wins unless STARVE_LIMIT≠0 and starve==STARVE_LIMIT, in which case IF wins.
- Starve counter (4 bit, saturating):
  - +1 when MEM wins while if_req=1.
  - Cleared when IF wins.
  - Unchanged when MEM wins with if_req=0.
- mem_re & mem_we both high: treated as a write. rdata register is not updated.
- ready outputs and the rdata register are registered. Stall outputs are combinational from req and the registered ready.
- Non-owner ready is always 0. if_ready and mem_ready are never high in the same cycle.
- ram_address and ram_data hold their last values outside ACCESS. Strobes are 0 outside ACCESS.

Test Plan:
- Reset, then single IF read of 0x0000_0040 with ram_rdata=0xDEAD_BEEF valid at the expected cycle -> ram_re high only in cycle 1; if_ready in cycle 3; if_rdata=0xDEAD_BEEF; if_stall high in cycles 0–2.
- MEM write addr 0x100, wdata 0x1234_5678 -> ram_we=1 with ram_address=0x100 and ram_data=0x1234_5678 in cycle 1 only; mem_ready in cycle 2; rdata register unchanged.
- IF and MEM read requests continuously asserted, STARVE_LIMIT=4 -> grant order MEM,MEM,MEM,MEM,IF, repeating. With STARVE_LIMIT=0, IF is never granted while MEM requests.
- RAM_LAT=3 read -> ram_re in cycle 1, capture at end of cycle 4, mem_ready in cycle 5.
- rst asserted in the WAIT cycle of a read -> strobes and ready drop in the same cycle; no ready pulse. After release with req still held, the read reissues and completes with correct data.
- mem_re=mem_we=1 -> write performed, mem_ready in cycle 2, ram_re never asserted.
